uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
Serial-to-byte UART receiver that feeds uart_debug's uart_rx/uart_rx_valid/uart_rx_ready command input. It recovers 8N1 frames from the asynchronous rx pin by mid-bit sampling. Received bytes are buffered in a small FIFO and presented on a valid/ready stream, so uart_debug can stall while an AXI read is outstanding without losing incoming command bytes. It is the receive-side counterpart of uart_tx and uses the same MAIN_CLK/BAUD parameterisation.

Parameters:
MAIN_CLK, 12000000, clk frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = MAIN_CLK/BAUD (integer division), must be >= 4
FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock
reset_  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
data_out  out  8  received byte at FIFO head
data_out_valid  out  1  FIFO non-empty
data_out_ready  in  1  consumer accepts data_out this cycle when valid
frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
overrun  out  1  one-cycle pulse: good byte received while FIFO full, byte discarded
busy  out  1  high while receive FSM is not in IDLE

Behaviour:
- Reset (reset_ low, async): synchroniser flops = 1; FSM = IDLE; counters = 0; FIFO empty; data_out = 0; data_out_valid, frame_err, overrun, busy = 0. Reset mid-frame abandons the frame, and no partial byte is ever written.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Bit counter clk_cnt counts 0..CLKS_PER_BIT-1; bit index 0..7.
- FSM:
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: at clk_cnt==CLKS_PER_BIT/2-1, sample rx_s. If 1 (glitch) -> IDLE with no flags. If 0 -> DATA, clk_cnt=0, index=0.
  - DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into the shift register LSB-first and clear clk_cnt. After index 7 -> STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: push the byte into the FIFO if not full; if full, pulse overrun and drop the byte. Then -> IDLE.
    - If 0: pulse frame_err, drop the byte -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line from being read as back-to-back 0x00 frames.
- Latency: the byte is visible on data_out with data_out_valid=1 on the cycle after the stop-bit sample when the FIFO was empty.
- FIFO: first-word-fall-through; data_out reflects the head entry whenever valid.
  - Pop on data_out_valid && data_out_ready.
  - Push and pop in the same cycle are both honoured. When full, a simultaneous pop frees the slot and the push is accepted, with no overrun.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty are decided by the MSB comparison.
- data_out_valid must not depend combinationally on data_out_ready. data_out is stable while valid && !ready.
- frame_err and overrun are registered single-cycle pulses and never assert simultaneously.

Test Plan:
1. MAIN_CLK=8, BAUD=1, ready held 1; send frames 0x03, 0x76, 0x48 -> data_out shows 0x03, 0x76, 0x48 in order, each valid for exactly 1 cycle, 1 cycle after the respective stop sample; frame_err=overrun=0.
2. ready held 0; send 5 bytes 0x00, 0xFF, 0x1A, 0xA5, 0x55 (FIFO_DEPTH=4) -> overrun pulses once, on the 5th byte. Then raise ready -> pops 0x00, 0xFF, 0x1A, 0xA5; 0x55 is never delivered.
3. FIFO full, ready pulsed for 1 cycle coinciding with the 5th byte's stop sample -> 0x00 popped, 5th byte accepted, no overrun; remaining order 0xFF, 0x1A, 0xA5, 5th byte.
4. Send 0x5A with stop bit driven low, then hold rx low 30 bits, then release, then send 0x3C -> frame_err pulses once; only 0x3C is delivered.
5. rx low glitch of CLKS_PER_BIT/2-2 cycles in IDLE -> busy returns low after the half-bit check, no byte, no flags; a following 0x81 frame is received correctly.
6. Assert reset_ low mid-way through the data bits of 0xC3, release it, then send 0x7E -> only 0x7E is delivered; all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: mid-bit sampling of the rx pin into a first-word-fall-through
// byte FIFO presented as a valid/ready stream, with frame-error and overrun pulses.
module uart_rx_deser #(
  parameter int MAIN_CLK   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = MAIN_CLK / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             rx_sync_p0;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_nx;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nx;
  logic             push;
  logic             pop;
  logic             frame_err_nx;
  logic             overrun_nx;

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic             fifo_full;
  logic             fifo_empty;

  // Stage p0/p1: two-flop synchroniser; rx_s is the only view of the line used below
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= rx;
      rx_s       <= rx_sync_p0;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = data_out_valid && data_out_ready;

  always_comb begin
    state_nx     = state;
    cnt_nx       = clk_cnt;
    idx_nx       = bit_idx;
    shreg_nx     = shreg;
    push         = 1'b0;
    frame_err_nx = 1'b0;
    overrun_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            idx_nx   = '0;
          end
        end else begin
          cnt_nx = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            idx_nx = bit_idx + 1'b1;
          end
        end else begin
          cnt_nx = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            // A pop in the same cycle frees the slot, so a full FIFO can still take the byte
            if (!fifo_full || pop) begin
              push = 1'b1;
            end else begin
              overrun_nx = 1'b1;
            end
            state_nx = IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = BRK;
          end
        end else begin
          cnt_nx = clk_cnt + 1'b1;
        end
      end
      BRK: begin
        // Hold off until the line returns high so a stuck-low line is not read as 0x00 frames
        if (rx_s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Stage p2: FSM, counters, FIFO pointers and flag pulses
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      clk_cnt   <= cnt_nx;
      bit_idx   <= idx_nx;
      frame_err <= frame_err_nx;
      overrun   <= overrun_nx;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= shreg;
    end
  end

  assign data_out_valid = !fifo_empty;
  assign data_out       = data_out_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames are driven on rx, expected bytes are queued
// and a negedge monitor pops and compares every accepted output byte.
module tb_uart_rx_deser;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       rx = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  logic [7:0] exp_q[$];

  uart_rx_deser #(
    .MAIN_CLK  (8),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset_        (reset_),
    .rx            (rx),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", name, act, req);
    end
  endtask

  task automatic checkn(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h want none", data_out);
      end else begin
        e = exp_q.pop_front();
        check8("sb_byte", data_out, e);
      end
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (frame_err || overrun) check1("flags_exclusive", frame_err & overrun, 1'b0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge; the stop-bit level is left on the line afterwards
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  // Stop bit is sampled on the 79th edge after the start bit is driven
  task automatic chk_latency(input logic [7:0] b);
    repeat (78) @(posedge clk);
    @(negedge clk);
    check1("lat_pre", data_out_valid, 1'b0);
    @(negedge clk);
    check1("lat_valid", data_out_valid, 1'b1);
    check8("lat_data", data_out, b);
    @(negedge clk);
    check1("lat_one_cycle", data_out_valid, 1'b0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    idle(3 * CPB);
    checkn({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int fe0;
    int ov0;
    logic saw_busy;
    logic [7:0] t1 [3];
    logic [7:0] t2 [5];

    t1[0] = 8'h03; t1[1] = 8'h76; t1[2] = 8'h48;
    t2[0] = 8'h00; t2[1] = 8'hFF; t2[2] = 8'h1A; t2[3] = 8'hA5; t2[4] = 8'h55;

    // Reset state
    idle(3);
    @(negedge clk);
    check8("rst_data", data_out, 8'h00);
    check1("rst_valid", data_out_valid, 1'b0);
    check1("rst_ferr", frame_err, 1'b0);
    check1("rst_ovr", overrun, 1'b0);
    check1("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_ = 1'b1;
    idle(4);

    // Test 1: streaming with ready held high
    data_out_ready = 1'b1;
    fe0 = n_ferr; ov0 = n_ovr;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t1[i]);
      fork
        send_frame(t1[i], 1'b1);
        chk_latency(t1[i]);
      join
      idle(2);
    end
    drain("t1");
    checkn("t1_ferr", n_ferr - fe0, 0);
    checkn("t1_ovr", n_ovr - ov0, 0);

    // Test 2: overrun on the fifth byte while stalled
    data_out_ready = 1'b0;
    ov0 = n_ovr;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(t2[i]);
      if (i == 4) checkn("t2_ovr_before5", n_ovr - ov0, 0);
      send_frame(t2[i], 1'b1);
      idle(2);
    end
    checkn("t2_ovr", n_ovr - ov0, 1);
    data_out_ready = 1'b1;
    drain("t2");

    // Test 3: full FIFO, single-cycle pop coinciding with the fifth stop sample
    data_out_ready = 1'b0;
    ov0 = n_ovr;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(t2[i]);
      send_frame(t2[i], 1'b1);
      idle(2);
    end
    exp_q.push_back(8'hC7);
    fork
      send_frame(8'hC7, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1 data_out_ready = 1'b1;
        @(posedge clk);
        #1 data_out_ready = 1'b0;
      end
    join
    idle(2);
    checkn("t3_ovr", n_ovr - ov0, 0);
    checkn("t3_queued", exp_q.size(), 4);
    data_out_ready = 1'b1;
    drain("t3");

    // Test 4: framing error followed by a held-low break
    fe0 = n_ferr; ov0 = n_ovr;
    send_frame(8'h5A, 1'b0);
    idle(30 * CPB);
    rx = 1'b1;
    idle(3 * CPB);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drain("t4");
    checkn("t4_ferr", n_ferr - fe0, 1);
    checkn("t4_ovr", n_ovr - ov0, 0);

    // Test 5: short low glitch in idle
    fe0 = n_ferr; ov0 = n_ovr;
    saw_busy = 1'b0;
    rx = 1'b0;
    idle(CPB / 2 - 2);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check1("t5_busy_seen", saw_busy, 1'b1);
    check1("t5_busy_low", busy, 1'b0);
    check1("t5_no_valid", data_out_valid, 1'b0);
    idle(2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drain("t5");
    checkn("t5_ferr", n_ferr - fe0, 0);
    checkn("t5_ovr", n_ovr - ov0, 0);

    // Test 6: reset in the middle of 0xC3's data bits
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
    rx = 1'b0;
    idle(CPB / 2);
    check1("t6_busy_before", busy, 1'b1);
    reset_ = 1'b0;
    rx = 1'b1;
    idle(3);
    @(negedge clk);
    check8("t6_rst_data", data_out, 8'h00);
    check1("t6_rst_valid", data_out_valid, 1'b0);
    check1("t6_rst_ferr", frame_err, 1'b0);
    check1("t6_rst_ovr", overrun, 1'b0);
    check1("t6_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_ = 1'b1;
    idle(4 * CPB);
    check1("t6_no_partial", data_out_valid, 1'b0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
